// File: rtl/bit_scan_controller.sv
// bit_scan_controller
//   Drives a 7-to-1 bit-select multiplexer. A start request latches a 7-bit
//   word. The sequencer then steps the select through all seven positions,
//   holding each one for TICKS_PER_BIT cycles, and captures the multiplexer
//   output back into a reassembled word.
//
// Parameters
//   TICKS_PER_BIT : cycles each select value is held (1..65535)
//   LSB_FIRST     : 1 = select order 0..6, 0 = select order 6..0
//
// Ports
//   i_clock       : clock, rising edge
//   i_reset       : synchronous active-high reset
//   i_start       : scan request, sampled only in IDLE
//   i_data_in     : word latched when i_start is accepted
//   i_mux_out     : multiplexer output, fed back for capture
//   o_mux_select  : multiplexer select (never 3'b111)
//   o_mux_input   : multiplexer data input (the latched word)
//   o_bit_strobe  : high in the last cycle of each bit period
//   o_busy        : high while scanning
//   o_done        : one-cycle pulse after the 7th bit is captured
//   o_captured    : reassembled word, bit s sampled while select = s
module bit_scan_controller #(
   parameter int unsigned TICKS_PER_BIT = 4,
   parameter bit          LSB_FIRST     = 1'b1
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [6:0] i_data_in,
   input  logic       i_mux_out,
   output logic [2:0] o_mux_select,
   output logic [6:0] o_mux_input,
   output logic       o_bit_strobe,
   output logic       o_busy,
   output logic       o_done,
   output logic [6:0] o_captured
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_t;

   localparam logic [15:0] LP_TICK_LAST = 16'(TICKS_PER_BIT - 1);
   localparam logic [2:0]  LP_SEL_FIRST = LSB_FIRST ? 3'd0 : 3'd6;
   localparam logic [2:0]  LP_SEL_LAST  = LSB_FIRST ? 3'd6 : 3'd0;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_tick;
   logic [2:0]  r_sel;
   logic [6:0]  r_word;
   logic [6:0]  r_cap;
   logic        r_busy;
   logic        w_strobe;
   logic        w_done;
   logic        w_last;
   logic [2:0]  w_sel_step;

   assign w_last     = (r_sel == LP_SEL_LAST);
   assign w_sel_step = LSB_FIRST ? (r_sel + 3'd1) : (r_sel - 3'd1);

   // Next-state and decoded outputs
   always_comb begin
      w_state_nxt = r_state;
      w_strobe    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_nxt = ST_SCAN;
         end
         ST_SCAN: begin
            w_strobe = (r_tick == LP_TICK_LAST);
            if (w_strobe && w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Datapath: the select and the word are left untouched outside an accepted
   // start or an active scan, so they hold their last values in IDLE.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_tick <= '0;
         r_sel  <= '0;
         r_word <= '0;
         r_cap  <= '0;
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_SCAN);
         if (r_state == ST_IDLE && i_start) begin
            r_word <= i_data_in;
            r_cap  <= '0;
            r_sel  <= LP_SEL_FIRST;
            r_tick <= '0;
         end else if (r_state == ST_SCAN) begin
            if (w_strobe) begin
               r_cap[r_sel] <= i_mux_out;
               r_tick       <= '0;
               if (!w_last) r_sel <= w_sel_step;
            end else begin
               r_tick <= r_tick + 16'd1;
            end
         end
      end
   end

   assign o_mux_select = r_sel;
   assign o_mux_input  = r_word;
   assign o_captured   = r_cap;
   assign o_busy       = r_busy;
   assign o_bit_strobe = w_strobe;
   assign o_done       = w_done;

endmodule

// File: tb/tb_bit_scan_controller.sv
// tb_bit_scan_controller
//   Directed bench for bit_scan_controller. Three instances cover
//   T=4/LSB-first, T=2/MSB-first and T=1/LSB-first. Each instance has an
//   ideal multiplexer in loopback.
module tb_bit_scan_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic       rst_a, st_a, mo_a, bs_a, bz_a, dn_a;
   logic [6:0] din_a, mi_a, cp_a;
   logic [2:0] ms_a;
   logic       rst_b, st_b, mo_b, bs_b, bz_b, dn_b;
   logic [6:0] din_b, mi_b, cp_b;
   logic [2:0] ms_b;
   logic       rst_c, st_c, mo_c, bs_c, bz_c, dn_c;
   logic [6:0] din_c, mi_c, cp_c;
   logic [2:0] ms_c;

   assign mo_a = (ms_a < 3'd7) ? mi_a[ms_a] : 1'b0;
   assign mo_b = (ms_b < 3'd7) ? mi_b[ms_b] : 1'b0;
   assign mo_c = (ms_c < 3'd7) ? mi_c[ms_c] : 1'b0;

   bit_scan_controller #(.TICKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut_a (
      .i_clock(clk), .i_reset(rst_a), .i_start(st_a), .i_data_in(din_a),
      .i_mux_out(mo_a), .o_mux_select(ms_a), .o_mux_input(mi_a),
      .o_bit_strobe(bs_a), .o_busy(bz_a), .o_done(dn_a), .o_captured(cp_a));

   bit_scan_controller #(.TICKS_PER_BIT(2), .LSB_FIRST(1'b0)) dut_b (
      .i_clock(clk), .i_reset(rst_b), .i_start(st_b), .i_data_in(din_b),
      .i_mux_out(mo_b), .o_mux_select(ms_b), .o_mux_input(mi_b),
      .o_bit_strobe(bs_b), .o_busy(bz_b), .o_done(dn_b), .o_captured(cp_b));

   bit_scan_controller #(.TICKS_PER_BIT(1), .LSB_FIRST(1'b1)) dut_c (
      .i_clock(clk), .i_reset(rst_c), .i_start(st_c), .i_data_in(din_c),
      .i_mux_out(mo_c), .o_mux_select(ms_c), .o_mux_input(mi_c),
      .o_bit_strobe(bs_c), .o_busy(bz_c), .o_done(dn_c), .o_captured(cp_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; st_a = 1'b0; din_a = '0;
      rst_b = 1'b1; st_b = 1'b0; din_b = '0;
      rst_c = 1'b1; st_c = 1'b0; din_c = '0;
      repeat (3) step();
      chk("reset_a", 32'({ms_a, mi_a, cp_a, bs_a, bz_a, dn_a}), 32'd0);
      chk("reset_b", 32'({ms_b, mi_b, cp_b, bs_b, bz_b, dn_b}), 32'd0);
      chk("reset_c", 32'({ms_c, mi_c, cp_c, bs_c, bz_c, dn_c}), 32'd0);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      step();

      // A: T=4, LSB first; extra start requests in cycles 5 and 29 are ignored
      st_a = 1'b1; din_a = 7'b1010011;
      for (int c = 1; c <= 29; c++) begin
         step();
         case (c)
            1:  st_a = 1'b0;
            5:  begin st_a = 1'b1; din_a = 7'h7F; end
            6:  st_a = 1'b0;
            29: st_a = 1'b1;
            default: ;
         endcase
         chk("a_sel",    32'(ms_a), (c <= 28) ? 32'((c - 1) / 4) : 32'd6);
         chk("a_strobe", 32'(bs_a), 32'((c <= 28) && (c % 4 == 0)));
         chk("a_busy",   32'(bz_a), 32'(c <= 28));
         chk("a_done",   32'(dn_a), 32'(c == 29));
         chk("a_muxin",  32'(mi_a), 32'h53);
      end
      chk("a_capt", 32'(cp_a), 32'h53);
      step(); // cycle 30: IDLE, start accepted
      chk("a_idle_busy", 32'(bz_a), 32'd0);
      chk("a_idle_done", 32'(dn_a), 32'd0);
      chk("a_idle_sel",  32'(ms_a), 32'd6);
      chk("a_idle_capt", 32'(cp_a), 32'h53);
      step(); // cycle 31: second scan, bit 0
      st_a = 1'b0;
      chk("a2_busy",  32'(bz_a), 32'd1);
      chk("a2_muxin", 32'(mi_a), 32'h7F);
      chk("a2_sel",   32'(ms_a), 32'd0);
      chk("a2_capt",  32'(cp_a), 32'd0);

      // Reset in cycle 10 of the second scan (absolute cycle 40)
      repeat (9) step();
      chk("a2_sel_c10", 32'(ms_a), 32'd2);
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      chk("a_midreset", 32'({ms_a, mi_a, cp_a, bs_a, bz_a, dn_a}), 32'd0);
      step();
      chk("a_post_reset_busy", 32'(bz_a), 32'd0);
      st_a = 1'b1; din_a = 7'b0110101;
      for (int c = 1; c <= 29; c++) begin
         step();
         if (c == 1) st_a = 1'b0;
         chk("a3_done", 32'(dn_a), 32'(c == 29));
         chk("a3_busy", 32'(bz_a), 32'(c <= 28));
      end
      chk("a3_capt", 32'(cp_a), 32'h35);

      // B: T=2, MSB first
      st_b = 1'b1; din_b = 7'b0111000;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (c == 1) st_b = 1'b0;
         if (c <= 14) begin
            chk("b_sel",    32'(ms_b), 32'(6 - (c - 1) / 2));
            chk("b_strobe", 32'(bs_b), 32'(c % 2 == 0));
         end
         chk("b_done", 32'(dn_b), 32'(c == 15));
      end
      chk("b_capt", 32'(cp_b), 32'h38);

      // C: T=1, start held high, back-to-back scans every 9 cycles
      st_c = 1'b1; din_c = 7'h55;
      for (int c = 1; c <= 40; c++) begin
         step();
         chk("c_sel_not7", 32'(ms_c == 3'd7), 32'd0);
         chk("c_done",     32'(dn_c), 32'(c % 9 == 8));
         chk("c_busy",     32'(bz_c), 32'((c % 9 >= 1) && (c % 9 <= 7)));
         if (c % 9 == 8) chk("c_capt", 32'(cp_c), 32'h55);
      end
      st_c = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
